// File: rtl/r16_pipe_pkg.sv
// Shared constants and helpers for the r16 elastic pipeline stage.
// Width/depth defaults and the occupancy counter width live here.
package r16_pipe_pkg;

   localparam int R16_DEFAULT_WIDTH = 64;
   localparam int R16_MAX_DEPTH     = 8;

   // Counter must represent 0..depth inclusive.
   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage : r16_pipe_pkg

// File: rtl/r16_pipe_slot.sv
// One pipeline slot: valid bit plus {A0, Ac, N, D} payload, loaded when load_i is high.
// With R16_PIPE_FLUSH_EN defined a clear_i input drops the valid bit and leaves the payload alone.
module r16_pipe_slot
   import r16_pipe_pkg::*;
#(
   parameter int P_WIDTH = R16_DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
`ifdef R16_PIPE_FLUSH_EN
   input  logic               clear_i,
`endif
   input  logic               load_i,
   input  logic               valid_i,
   input  logic               ac_i,
   input  logic [P_WIDTH-1:0] a0_i,
   input  logic [P_WIDTH-1:0] n_i,
   input  logic [P_WIDTH-1:0] d_i,
   output logic               valid_o,
   output logic               ac_o,
   output logic [P_WIDTH-1:0] a0_o,
   output logic [P_WIDTH-1:0] n_o,
   output logic [P_WIDTH-1:0] d_o
);

   logic               valid_q, valid_d;
   logic               ac_q, ac_d;
   logic [P_WIDTH-1:0] a0_q, a0_d;
   logic [P_WIDTH-1:0] n_q, n_d;
   logic [P_WIDTH-1:0] d_q, d_d;

   always_comb begin
      valid_d = valid_q;
      ac_d    = ac_q;
      a0_d    = a0_q;
      n_d     = n_q;
      d_d     = d_q;
      // Payload loads even for an invalid source word; its value is don't-care.
      if (load_i) begin
         valid_d = valid_i;
         ac_d    = ac_i;
         a0_d    = a0_i;
         n_d     = n_i;
         d_d     = d_i;
      end
`ifdef R16_PIPE_FLUSH_EN
      if (clear_i) begin
         valid_d = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         ac_q    <= 1'b0;
         a0_q    <= '0;
         n_q     <= '0;
         d_q     <= '0;
      end else begin
         valid_q <= valid_d;
         ac_q    <= ac_d;
         a0_q    <= a0_d;
         n_q     <= n_d;
         d_q     <= d_d;
      end
   end

   assign valid_o = valid_q;
   assign ac_o    = ac_q;
   assign a0_o    = a0_q;
   assign n_o     = n_q;
   assign d_o     = d_q;

endmodule : r16_pipe_slot

// File: rtl/r16_pipe_stage_n.sv
// P_DEPTH-deep elastic register pipeline with bubble compression and an occupancy counter.
// Optional macro R16_PIPE_FLUSH_EN adds a synchronous flush input that empties every slot.
module r16_pipe_stage_n
   import r16_pipe_pkg::*;
#(
   parameter int P_WIDTH = R16_DEFAULT_WIDTH,
   parameter int P_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
`ifdef R16_PIPE_FLUSH_EN
   input  logic                            flush,
`endif
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [P_WIDTH-1:0]              A0_in,
   input  logic [P_WIDTH-1:0]              N_in,
   input  logic [P_WIDTH-1:0]              D_in,
   input  logic                            Ac_in,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [P_WIDTH-1:0]              A0_out,
   output logic [P_WIDTH-1:0]              N_Dn_out,
   output logic [P_WIDTH-1:0]              D_out,
   output logic                            Ac_out,
   output logic [occ_width(P_DEPTH)-1:0]   occupancy
);

   localparam int OCC_W = occ_width(P_DEPTH);

   if (P_DEPTH < 1 || P_DEPTH > R16_MAX_DEPTH) begin : g_bad_depth
      $error("r16_pipe_stage_n: P_DEPTH out of range 1..8");
   end

   logic [P_DEPTH-1:0] adv;
   logic [P_DEPTH-1:0] load_en;
   logic [P_DEPTH-1:0] valid_s;
   logic [P_DEPTH-1:0] ac_s;
   logic [P_WIDTH-1:0] a0_s [P_DEPTH];
   logic [P_WIDTH-1:0] n_s  [P_DEPTH];
   logic [P_WIDTH-1:0] d_s  [P_DEPTH];

   logic [P_DEPTH-1:0] src_valid;
   logic [P_DEPTH-1:0] src_ac;
   logic [P_WIDTH-1:0] src_a0 [P_DEPTH];
   logic [P_WIDTH-1:0] src_n  [P_DEPTH];
   logic [P_WIDTH-1:0] src_d  [P_DEPTH];

   logic               tail_full;
   logic               in_xfer;
   logic               out_xfer;
   logic [OCC_W-1:0]   occ_q, occ_d;

   // Slot k may advance unless it and every slot downstream of it are full while
   // the consumer stalls; the closed form avoids a bit-to-bit combinational chain.
   always_comb begin
      adv       = '0;
      tail_full = 1'b1;
      for (int k = 0; k < P_DEPTH; k++) begin
         tail_full = 1'b1;
         for (int j = k; j < P_DEPTH; j++) begin
            tail_full = tail_full & valid_s[j];
         end
         adv[k] = out_ready | ~tail_full;
      end
   end

`ifdef R16_PIPE_FLUSH_EN
   assign load_en  = adv & ~{P_DEPTH{flush}};
   assign in_ready = adv[0] & ~flush;
`else
   assign load_en  = adv;
   assign in_ready = adv[0];
`endif

   for (genvar k = 0; k < P_DEPTH; k++) begin : g_slot
      if (k == 0) begin : g_head
         assign src_valid[k] = in_valid;
         assign src_ac[k]    = Ac_in;
         assign src_a0[k]    = A0_in;
         assign src_n[k]     = N_in;
         assign src_d[k]     = D_in;
      end else begin : g_body
         assign src_valid[k] = valid_s[k-1];
         assign src_ac[k]    = ac_s[k-1];
         assign src_a0[k]    = a0_s[k-1];
         assign src_n[k]     = n_s[k-1];
         assign src_d[k]     = d_s[k-1];
      end

      r16_pipe_slot #(
         .P_WIDTH (P_WIDTH)
      ) u_slot (
         .clk     (clk),
         .rst_n   (rst_n),
`ifdef R16_PIPE_FLUSH_EN
         .clear_i (flush),
`endif
         .load_i  (load_en[k]),
         .valid_i (src_valid[k]),
         .ac_i    (src_ac[k]),
         .a0_i    (src_a0[k]),
         .n_i     (src_n[k]),
         .d_i     (src_d[k]),
         .valid_o (valid_s[k]),
         .ac_o    (ac_s[k]),
         .a0_o    (a0_s[k]),
         .n_o     (n_s[k]),
         .d_o     (d_s[k])
      );
   end

   assign out_valid = valid_s[P_DEPTH-1];
   assign Ac_out    = ac_s[P_DEPTH-1];
   assign A0_out    = a0_s[P_DEPTH-1];
   assign N_Dn_out  = n_s[P_DEPTH-1];
   assign D_out     = d_s[P_DEPTH-1];

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   always_comb begin
      occ_d = occ_q;
      case ({in_xfer, out_xfer})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
`ifdef R16_PIPE_FLUSH_EN
      if (flush) begin
         occ_d = '0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign occupancy = occ_q;

endmodule : r16_pipe_stage_n
